// File: rtl/tcm_boot_monitor_if.sv
// Image stream in, TCM instruction write port out; slave side belongs to the boot monitor.
// The stream is valid/ready; the TCM write port has no backpressure.
interface tcm_boot_monitor_if #(
    parameter int ADDR_W = 32
) ();
    logic              ld_valid_i;
    logic [31:0]       ld_data_i;
    logic              ld_ready_o;
    logic [3:0]        tb_inst_we_o;
    logic [ADDR_W-1:0] tb_inst_addr_o;
    logic [31:0]       tb_inst_data_o;

    modport master (
        output ld_valid_i,
        output ld_data_i,
        input  ld_ready_o,
        input  tb_inst_we_o,
        input  tb_inst_addr_o,
        input  tb_inst_data_o
    );

    modport slave (
        input  ld_valid_i,
        input  ld_data_i,
        output ld_ready_o,
        output tb_inst_we_o,
        output tb_inst_addr_o,
        output tb_inst_data_o
    );
endinterface

// File: rtl/tcm_boot_monitor.sv
// Boot sequencer: streams an image into the TCM, pulses core reset, then counts branch-prediction stats.
// TCM write lands one cycle after each handshake; ld_ready is high only in LOAD and stalls indefinitely on valid.
module tcm_boot_monitor #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                WCNT_W         = 16,
    parameter int                CPU_RST_CYCLES = 1,
    parameter int                DRAIN_CYCLES   = 50,
    parameter int                MAX_RUN_CYCLES = 40000,
    parameter int                CNT_W          = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WCNT_W-1:0]  num_words_i,
    input  logic [31:0]        stop_pc_i,
    tcm_boot_monitor_if.slave  bus,
    output logic               rst_cpu_o,
    input  logic               mon_br_vld_i,
    input  logic               mon_taken_i,
    input  logic               mon_pred_i,
    input  logic               mon_pc_vld_i,
    input  logic [31:0]        mon_pc_i,
    output logic [CNT_W-1:0]   cnt_branch_o,
    output logic [CNT_W-1:0]   cnt_hit_o,
    output logic [CNT_W-1:0]   cnt_miss_o,
    output logic [CNT_W-1:0]   cnt_cycle_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CPURST = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int RST_W = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int RUN_W = (MAX_RUN_CYCLES > 1) ? $clog2(MAX_RUN_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(CPU_RST_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic                to_timeout;

    logic [WCNT_W-1:0]   nwords_q;
    logic [WCNT_W-1:0]   idx_q;
    logic [31:0]         stop_pc_q;
    logic [RST_W-1:0]    rst_cnt_q;
    logic [DRN_W-1:0]    drn_cnt_q;
    logic [RUN_W-1:0]    run_cnt_q;

    logic [3:0]          we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;

    logic [CNT_W-1:0]    cnt_branch_q;
    logic [CNT_W-1:0]    cnt_hit_q;
    logic [CNT_W-1:0]    cnt_miss_q;
    logic [CNT_W-1:0]    cnt_cycle_q;

    logic                rst_cpu_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;

    logic                start_ok;
    logic                ld_hs;
    logic                last_word;
    logic                stop_hit;
    logic                counting;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign start_ok  = start_i && !abort_i && (state_q == S_IDLE || state_q == S_DONE);
    assign ld_hs     = bus.ld_valid_i && (state_q == S_LOAD);
    assign last_word = (idx_q == nwords_q - 1'b1);
    assign stop_hit  = mon_pc_vld_i && (mon_pc_i == stop_pc_q);
    assign counting  = (state_q == S_RUN || state_q == S_DRAIN) && !abort_i;

    always_comb begin
        state_d    = state_q;
        to_timeout = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = (num_words_i == '0) ? S_CPURST : S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_hs && last_word) begin
                    state_d = S_CPURST;
                end
            end
            S_CPURST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Stop PC outranks the run cap when both land in the same cycle.
                if (stop_hit) begin
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d    = S_DONE;
                    to_timeout = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == DRN_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d    = S_IDLE;
            to_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nwords_q     <= '0;
            idx_q        <= '0;
            stop_pc_q    <= '0;
            rst_cnt_q    <= '0;
            drn_cnt_q    <= '0;
            run_cnt_q    <= '0;
            we_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_branch_q <= '0;
            cnt_hit_q    <= '0;
            cnt_miss_q   <= '0;
            cnt_cycle_q  <= '0;
            rst_cpu_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            we_q <= '0;
            // A word accepted in the abort cycle is dropped rather than written.
            if (ld_hs && !abort_i) begin
                we_q   <= 4'hF;
                addr_q <= BASE_ADDR + (ADDR_W'(idx_q) << 2);
                data_q <= bus.ld_data_i;
                idx_q  <= idx_q + 1'b1;
            end

            rst_cnt_q <= (state_q == S_CPURST && state_d == S_CPURST) ? rst_cnt_q + 1'b1 : '0;
            drn_cnt_q <= (state_q == S_DRAIN && state_d == S_DRAIN) ? drn_cnt_q + 1'b1 : '0;

            if (state_q == S_RUN && !abort_i) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end

            if (counting) begin
                cnt_cycle_q <= sat_inc(cnt_cycle_q);
                if (mon_br_vld_i) begin
                    cnt_branch_q <= sat_inc(cnt_branch_q);
                    if (mon_taken_i == mon_pred_i) begin
                        cnt_hit_q <= sat_inc(cnt_hit_q);
                    end else begin
                        cnt_miss_q <= sat_inc(cnt_miss_q);
                    end
                end
            end

            if (to_timeout) begin
                timeout_q <= 1'b1;
            end

            if (start_ok) begin
                nwords_q     <= num_words_i;
                stop_pc_q    <= stop_pc_i;
                idx_q        <= '0;
                run_cnt_q    <= '0;
                cnt_branch_q <= '0;
                cnt_hit_q    <= '0;
                cnt_miss_q   <= '0;
                cnt_cycle_q  <= '0;
                timeout_q    <= 1'b0;
            end

            // Status flags follow the next state so they line up with state_o.
            rst_cpu_q <= (state_d == S_IDLE || state_d == S_LOAD || state_d == S_CPURST);
            busy_q    <= (state_d == S_LOAD || state_d == S_CPURST ||
                          state_d == S_RUN  || state_d == S_DRAIN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign bus.ld_ready_o     = (state_q == S_LOAD);
    assign bus.tb_inst_we_o   = we_q;
    assign bus.tb_inst_addr_o = addr_q;
    assign bus.tb_inst_data_o = data_q;

    assign rst_cpu_o    = rst_cpu_q;
    assign cnt_branch_o = cnt_branch_q;
    assign cnt_hit_o    = cnt_hit_q;
    assign cnt_miss_o   = cnt_miss_q;
    assign cnt_cycle_o  = cnt_cycle_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

    // Every branch is either a hit or a miss, so the sum tracks the total until something saturates.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!(&cnt_branch_q) && !(&cnt_hit_q) && !(&cnt_miss_q)) |->
        (({1'b0, cnt_hit_q} + {1'b0, cnt_miss_q}) == {1'b0, cnt_branch_q}));

endmodule

// File: doc/tcm_boot_monitor.md
# tcm_boot_monitor

Synthesizable boot sequencer and branch-prediction monitor for `riscv_tcm_top`. It streams a program image into the instruction TCM through the `tb_inst_*` write port, then pulses `rst_cpu_i`. It monitors conditional-branch resolutions from the HPC, counting branches, hits and misses, stops a configurable number of cycles after a stop PC is reached, and flags a timeout. It generalises the bench-only load/reset/log sequence into a reusable, parametrised block usable on FPGA or in any bench.

## Interface
- `ADDR_W`, 32: TCM write address width.
- `BASE_ADDR`, 0: byte address of word 0.
- `WCNT_W`, 16: width of the word-count input (maximum image size 2^WCNT_W − 1 words).
- `CPU_RST_CYCLES`, 1: cycles `rst_cpu_o` stays high after the load completes (must be ≥1).
- `DRAIN_CYCLES`, 50: cycles counted after the stop PC is hit, before `DONE` (0 allowed).
- `MAX_RUN_CYCLES`, 40000: cycle cap for `RUN`, after which `timeout_o` is set.
- `CNT_W`, 32: width of each counter.
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  single-cycle start; accepted only in `IDLE` or `DONE`.
- `abort_i`  in  1  return to `IDLE` from any state.
- `num_words_i`  in  WCNT_W  number of words to load; sampled when `start_i` is accepted.
- `stop_pc_i`  in  32  stop PC; sampled when `start_i` is accepted.
- `ld_valid_i` / `ld_data_i[31:0]` / `ld_ready_o`  in/in/out  image stream (valid/ready).
- `tb_inst_we_o`  out  4  TCM byte write enable.
- `tb_inst_addr_o`  out  ADDR_W  TCM write address.
- `tb_inst_data_o`  out  32  TCM write data.
- `rst_cpu_o`  out  1  core reset.
- `mon_br_vld_i`  in  1  conditional branch resolved this cycle.
- `mon_taken_i` / `mon_pred_i`  in  1/1  actual and predicted outcome of the branch.
- `mon_pc_vld_i` / `mon_pc_i`  in  1/32  issue PC, used for stop-PC comparison.
- `cnt_branch_o` / `cnt_hit_o` / `cnt_miss_o` / `cnt_cycle_o`  out  CNT_W each  statistics.
- `busy_o` / `done_o` / `timeout_o`  out  1 each  status.
- `state_o`  out  3  encoded FSM state.

## Operation
- FSM states and encodings: `IDLE`(0), `LOAD`(1), `CPURST`(2), `RUN`(3), `DRAIN`(4), `DONE`(5).
- **`IDLE`**
  - `rst_cpu_o`=1.
  - An accepted `start_i` latches `num_words_i` and `stop_pc_i`, clears all counters and `timeout_o`, and clears the word index.
  - Next state is `LOAD`, or `CPURST` if `num_words_i`=0.
- **`LOAD`**
  - `ld_ready_o`=1.
  - Each handshake registers a write: `we`=4'hF, `addr`=`BASE_ADDR`+4·idx (modulo 2^ADDR_W), `data`=`ld_data_i`. The write appears the next cycle for exactly one cycle; `we`=0 otherwise.
  - The idx counter increments per handshake.
  - The handshake on the last word (idx = N−1) moves the FSM to `CPURST`.
  - Stalls on `ld_valid_i` are unbounded.
- **`CPURST`**
  - `rst_cpu_o`=1 for `CPU_RST_CYCLES` cycles, then the FSM enters `RUN` and `rst_cpu_o` drops to 0.
- **`RUN`**
  - `cnt_cycle_o` increments every cycle.
  - Each cycle with `mon_br_vld_i`: `cnt_branch_o`+1; if `mon_taken_i`==`mon_pred_i` then `cnt_hit_o`+1, else `cnt_miss_o`+1.
  - `mon_pc_vld_i` && `mon_pc_i`==stop PC → `DRAIN`.
  - Otherwise, `cnt_cycle_o` reaching `MAX_RUN_CYCLES` → `DONE` with `timeout_o`=1.
- **`DRAIN`**
  - Branch and cycle counting continue for `DRAIN_CYCLES` cycles, then the FSM enters `DONE`. With `DRAIN_CYCLES`=0 it goes straight to `DONE`.
- **`DONE`**
  - `done_o`=1; all counters are frozen; `rst_cpu_o`=0.
  - `start_i` restarts the sequence.
- `busy_o`=1 in `LOAD`, `CPURST`, `RUN` and `DRAIN`.
- All counters saturate at all-ones; they never wrap.
- Invariant: `cnt_hit_o` + `cnt_miss_o` == `cnt_branch_o` unless saturated.

## Timing
- Reset values:
  - `state_o`=`IDLE`, `rst_cpu_o`=1.
  - `tb_inst_we_o`=0, `tb_inst_addr_o`=0, `tb_inst_data_o`=0.
  - All counters 0.
  - `ld_ready_o`, `busy_o`, `done_o`, `timeout_o` all 0.
- All outputs are registered except `ld_ready_o`, which is decoded from state.
- Write latency: handshake in cycle t → `we`=4'hF in cycle t+1.
- The last word's write precedes the `rst_cpu_o` falling edge by at least `CPU_RST_CYCLES` cycles.
- Counter updates are visible one cycle after the event.
- The stop compare is sampled in `RUN` only; a stop PC seen in `DRAIN` or `CPURST` is ignored.
- Simultaneous events:
  - A branch in the same cycle as the stop PC is counted.
  - Stop PC and timeout in the same cycle: stop wins and the FSM enters `DRAIN`.
  - `abort_i` has priority over `start_i` and all transitions: next state `IDLE`, `rst_cpu_o`=1, `we`=0, counters hold their values.
- `start_i` outside `IDLE` or `DONE` is ignored.
- `rst_ni` asserted mid-operation returns every output to its reset value asynchronously.

## Test plan
- **Load and reset:** N=4, `BASE_ADDR`=0, continuous valid → writes to 0x0, 0x4, 0x8, 0xC on consecutive cycles with `we`=4'hF; `rst_cpu_o` falls 1 cycle after the last write (`CPU_RST_CYCLES`=1).
- **Backpressure:** N=3 with `ld_valid_i` gaps of 2 cycles → exactly 3 writes at the correct addresses; no write on gap cycles.
- **Prediction counting:** in `RUN`, inject 10 branches with 7 matching and 3 mismatching, including one on the stop-PC cycle → branch=10, hit=7, miss=3; `done_o` rises 50 cycles after the stop (`DRAIN_CYCLES`=50).
- **Timeout:** `MAX_RUN_CYCLES`=100, stop PC never presented → `DONE`, `timeout_o`=1, `cnt_cycle_o`=100.
- **Abort and reset:** `abort_i` mid-`LOAD` → `IDLE`, `rst_cpu_o`=1, no further writes. `rst_ni` low in `RUN` → all outputs at reset values.
- **Edge cases:** `num_words_i`=0 skips `LOAD`. A restart from `DONE` clears the counters. Saturation test with `CNT_W`=4 and 20 hits → `cnt_hit_o`=15.
